// File: rtl/spi_monarch.sv
// SPI mode-3 master for the iNEMO inertial sensor: one wrt launches a single
// DATA_W-bit full-duplex exchange; done and rd_data hold the result until the next wrt.
module spi_monarch #(
  parameter int unsigned DIV_W  = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_IDLE = DIV_W'(2**DIV_W - 9);
  localparam logic [DIV_W-1:0] DIV_SMPL = DIV_W'(2**(DIV_W-1) - 1);
  localparam logic [DIV_W-1:0] DIV_SHFT = '1;

  typedef enum logic [1:0] {
    IDLE,
    FRONT_PORCH,
    SHIFTING,
    BACK_PORCH
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [DATA_W-1:0] shft_q,  shft_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              smpl_q,  smpl_d;
  logic              ss_n_q,  ss_n_d;
  logic              done_q,  done_d;
  logic              smpl, shft;

  assign smpl    = (div_q == DIV_SMPL);
  assign shft    = (div_q == DIV_SHFT);
  assign SCLK    = div_q[DIV_W-1];
  assign MOSI    = shft_q[DATA_W-1];
  assign rd_data = shft_q;
  assign SS_n    = ss_n_q;
  assign done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= DIV_IDLE;
      shft_q  <= '0;
      cnt_q   <= '0;
      smpl_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      shft_q  <= shft_d;
      cnt_q   <= cnt_d;
      smpl_q  <= smpl_d;
      ss_n_q  <= ss_n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    shft_d  = shft_q;
    cnt_d   = cnt_q;
    smpl_d  = smpl_q;
    ss_n_d  = ss_n_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        div_d = DIV_IDLE;
        if (wrt) begin
          // The accepting cycle is the first divider step, so done lands 520 clocks
          // after the accepting edge; loading a constant keeps SCLK high back-to-back.
          div_d   = DIV_IDLE + 1'b1;
          shft_d  = cmd;
          cnt_d   = '0;
          done_d  = 1'b0;
          ss_n_d  = 1'b0;
          state_d = FRONT_PORCH;
        end
      end
      FRONT_PORCH: begin
        // MOSI already presents the MSB, so the first shft slot only wraps the divider.
        if (shft) state_d = SHIFTING;
      end
      SHIFTING: begin
        if (smpl) begin
          smpl_d = MISO;
          if (cnt_q == CNT_W'(DATA_W-1)) state_d = BACK_PORCH;
        end
        if (shft) begin
          shft_d = {shft_q[DATA_W-2:0], smpl_q};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      BACK_PORCH: begin
        if (shft) begin
          div_d   = div_q;
          shft_d  = {shft_q[DATA_W-2:0], smpl_q};
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_monarch.sv
// Bench for spi_monarch: drives command words against a behavioural iNEMO slave model
// and scores rd_data, latency and SCLK/MOSI framing against a queue of expected words.
module tb_spi_monarch;

  localparam int POR_CYC    = 1500;
  localparam int INT_PERIOD = 1000;
  localparam int LAT        = 520;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n, SCLK, MOSI;
  logic        MISO = 1'b0;

  always #5 clk = ~clk;

  spi_monarch #(.DIV_W(5), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural iNEMO slave (mode 3) ----------------
  logic [15:0] yaw       = 16'h0000;
  logic [7:0]  int1_ctrl = 8'h00;
  logic [7:0]  ctrl2_g   = 8'h00;
  logic        int_pin   = 1'b0;
  int          por_cnt   = 0;
  int          int_tmr   = 0;
  int          s_rises   = 0;
  int          s_falls   = 0;
  logic        s_sclk_p  = 1'b1;
  logic        s_ss_p    = 1'b1;
  logic [15:0] s_rx      = '0;
  logic [15:0] s_tx      = '0;

  function automatic logic [7:0] sens_rd(input logic [6:0] a);
    case (a)
      7'h0F:   return 8'h6A;
      7'h0D:   return int1_ctrl;
      7'h11:   return ctrl2_g;
      7'h26:   return yaw[7:0];
      7'h27:   return yaw[15:8];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (por_cnt < POR_CYC) por_cnt++;
    if (!SS_n && s_ss_p) begin
      s_rx = '0; s_tx = '0; s_rises = 0; s_falls = 0;
    end else if (!SS_n) begin
      if (SCLK && !s_sclk_p) begin
        s_rx = {s_rx[14:0], MOSI};
        s_rises++;
        if (s_rises == 8 && por_cnt >= POR_CYC)
          s_tx[7:0] = s_rx[7] ? sens_rd(s_rx[6:0]) : 8'hA5;
      end
      if (!SCLK && s_sclk_p && s_falls < 16) begin
        MISO <= s_tx[4'(15 - s_falls)];
        s_falls++;
      end
    end
    if (SS_n && !s_ss_p && s_rises == 16 && por_cnt >= POR_CYC) begin
      if (!s_rx[15] && s_rx[14:8] == 7'h0D) int1_ctrl = s_rx[7:0];
      if (!s_rx[15] && s_rx[14:8] == 7'h11) ctrl2_g   = s_rx[7:0];
      if (s_rx[15] && s_rx[14:8] == 7'h26)  int_pin   = 1'b0;
    end
    if (int1_ctrl == 8'h02 && ctrl2_g == 8'h60) begin
      int_tmr++;
      if (int_tmr >= INT_PERIOD) begin
        int_pin = 1'b1;
        int_tmr = 0;
      end
    end
    s_sclk_p = SCLK;
    s_ss_p   = SS_n;
  end

  // ---------------- pin monitor, sampled on the falling clk edge ----------------
  int          cyc = 0;
  int          m_rise = 0, m_fall = 0, m_tog = 0, m_idle_tog = 0;
  int          m_per_err = 0, m_mosi_err = 0, m_last_rise = 0, m_last_fall = 0;
  logic        m_sclk_p = 1'b1, m_ss_p = 1'b1, m_mosi_p = 1'b0, m_fell_p = 1'b0;
  logic [15:0] m_mosi_word = '0;

  always @(negedge clk) begin
    logic fell_now;
    cyc++;
    fell_now = !SCLK && m_sclk_p;
    if (!SS_n && m_ss_p) begin
      m_rise = 0; m_fall = 0;
    end
    if (SCLK !== m_sclk_p) begin
      m_tog++;
      if (SS_n && m_ss_p) m_idle_tog++;
      else if (!SS_n && SCLK) begin
        m_rise++;
        m_mosi_word = {m_mosi_word[14:0], MOSI};
        if (cyc - m_last_fall != 16) m_per_err++;
        m_last_rise = cyc;
      end else if (!SS_n) begin
        if (m_rise > 0 && cyc - m_last_rise != 16) m_per_err++;
        m_fall++;
        m_last_fall = cyc;
      end
    end
    if (!SS_n && !m_ss_p && MOSI !== m_mosi_p && !fell_now && !m_fell_p) m_mosi_err++;
    m_fell_p = fell_now;
    m_sclk_p = SCLK;
    m_ss_p   = SS_n;
    m_mosi_p = MOSI;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_wrt(input logic [15:0] c);
    cmd = c;
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic issue(input logic [15:0] c, input logic [7:0] exp);
    exp_q.push_back({8'h00, exp});
    pulse_wrt(c);
  endtask

  // lat counts clk edges after the accepting edge; wrt is pulsed at lat==pa/pb.
  task automatic wait_done(input int pa, input int pb, output int lat);
    lat = 0;
    while (!done && lat < 2000) begin
      if (lat == pa || lat == pb) begin
        cmd = 16'hA700;
        wrt = 1'b1;
      end
      @(negedge clk);
      wrt = 1'b0;
      lat++;
    end
  endtask

  task automatic complete(input string tag, input int pa, input int pb, input logic [15:0] c);
    int          lat;
    logic [15:0] exp;
    wait_done(pa, pb, lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_ssn_high"}, SS_n, 1'b1);
    check({tag, "_sclk_rises"}, m_rise, 16);
    check({tag, "_sclk_falls"}, m_fall, 16);
    check({tag, "_mosi_word"}, m_mosi_word, c);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_rd_data"}, rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tog0;
    int n;
    rst_n = 1'b0;
    wrt   = 1'b0;
    cmd   = '0;
    repeat (3) @(negedge clk);
    check("rst_ssn", SS_n, 1'b1);
    check("rst_sclk", SCLK, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a transaction
    pulse_wrt(16'h8F00);
    check("ssn_falls_after_wrt", SS_n, 1'b0);
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ssn", SS_n, 1'b1);
    check("abort_sclk", SCLK, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_rd_data", rd_data, 16'h0000);
    @(negedge clk);
    #1;
    tog0 = m_tog;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_no_sclk_edges", m_tog, tog0);
    check("abort_no_done", done, 1'b0);

    while (por_cnt < POR_CYC) @(negedge clk);
    @(negedge clk);

    issue(16'h8F00, 8'h6A);
    complete("who_am_i", -1, -1, 16'h8F00);

    issue(16'h0D02, 8'hA5);
    complete("wr_int1", -1, -1, 16'h0D02);
    @(negedge clk);
    check("int_idle_after_one_write", int_pin, 1'b0);
    issue(16'h1160, 8'hA5);
    complete("wr_ctrl2", -1, -1, 16'h1160);
    n = 0;
    while (!int_pin && n < 3 * INT_PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("int_pulse", int_pin, 1'b1);

    yaw = 16'h1234;
    issue(16'hA600, 8'h34);
    complete("yaw_lo", -1, -1, 16'hA600);
    repeat (2) @(negedge clk);
    check("int_cleared", int_pin, 1'b0);
    issue(16'hA700, 8'h12);
    complete("yaw_hi", -1, -1, 16'hA700);
    @(negedge clk);

    // wrt mid-transaction and on the done-rise cycle must be ignored
    issue(16'h8F00, 8'h6A);
    complete("hs_ignore", 99, 299, 16'h8F00);
    @(negedge clk);
    check("hs_ignore_done_held", done, 1'b1);
    check("hs_ignore_ssn_held", SS_n, 1'b1);

    issue(16'h8F00, 8'h6A);
    complete("hs_pre", LAT - 1, -1, 16'h8F00);
    @(negedge clk);
    check("hs_same_cycle_done_held", done, 1'b1);

    // wrt on the cycle after done rises starts a new transaction
    issue(16'h8F00, 8'h6A);
    complete("b2b_first", -1, -1, 16'h8F00);
    issue(16'hA700, 8'h12);
    check("b2b_done_cleared", done, 1'b0);
    check("b2b_ssn_low", SS_n, 1'b0);
    complete("b2b_second", -1, -1, 16'hA700);

    repeat (4) @(negedge clk);
    check("sclk_idle_toggles", m_idle_tog, 0);
    check("sclk_period_errors", m_per_err, 0);
    check("mosi_change_errors", m_mosi_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_monarch.md
Name: spi_monarch

Overview:
- Single-transaction SPI master that issues one 16-bit command to the iNEMO inertial sensor and returns the 16 bits shifted back.
- Sits directly upstream of the sensor, between the inertial command sequencer (wrt/cmd/done/rd_data) and the SS_n/SCLK/MOSI/MISO pins.
- SPI mode 3:
  - SCLK idles high.
  - Master changes MOSI on SCLK falling edges.
  - Master samples MISO on SCLK rising edges.
  - This matches a slave that drives on negedge and captures on posedge.

Parameters:
- DIV_W, 5: width of the SCLK divider. SCLK period = 2^DIV_W clk cycles (32).
- DATA_W, 16: bits per transaction.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrt  in  1  one-cycle start pulse; ignored unless in IDLE
- cmd  in  DATA_W  command word; cmd[15]=1 is a read, cmd[14:8] is the address, cmd[7:0] is write data; sampled on the wrt cycle
- done  out  1  set when a transaction completes; held until the next accepted wrt
- rd_data  out  DATA_W  word received from the slave; valid while done=1
- SS_n  out  1  active-low slave select
- SCLK  out  1  serial clock
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - SS_n=1, SCLK=1, done=0, rd_data=0.
  - Shift register cleared; divider loaded to 2^DIV_W-9 (5'b10111).
  - A reset mid-transaction aborts immediately with no done pulse.
- Datapath:
  - DATA_W shift register. MOSI = shft_reg[MSB]; rd_data = shft_reg.
  - DIV_W-bit divider SCLK_div; SCLK = SCLK_div[MSB], driven from a flop with no combinational glitch.
  - smpl event: SCLK_div == 0b01111 (SCLK rises next cycle). Capture MISO into a sample flop.
  - shft event: SCLK_div == 0b11111 (SCLK falls next cycle). shft_reg <= {shft_reg[DATA_W-2:0], MISO_smpl}; bit counter +1.
- IDLE:
  - SS_n=1, SCLK=1, divider held at 0b10111.
  - On wrt: load shft_reg=cmd, clear the bit counter, clear done, assert SS_n=0 next cycle, go to FRONT_PORCH.
- FRONT_PORCH:
  - Divider counts from 0b10111.
  - At the first 0b11111 no shift occurs, because MOSI already presents cmd[15].
  - Divider wraps (first SCLK fall); go to SHIFTING.
- SHIFTING:
  - Divider free-runs; smpl and shft act as defined.
  - When the bit counter reaches DATA_W-1 and the DATA_W-th smpl has occurred, go to BACK_PORCH.
- BACK_PORCH:
  - At divider 0b11111, perform the final shift.
  - Do not wrap the divider, so SCLK stays high and no extra falling edge occurs.
  - Set SS_n=1 and done=1, then return to IDLE.
- Timing:
  - Exactly DATA_W rising and DATA_W falling SCLK edges occur while SS_n=0.
  - SS_n falls one cycle after wrt.
  - done and SS_n rise 8 + DATA_W*2^DIV_W = 520 clk cycles after the wrt cycle.
- Handshake:
  - wrt while not IDLE is ignored; cmd is not resampled.
  - wrt in the same cycle done rises is ignored.
  - wrt on the following cycle starts a new transaction and clears done.
  - Back-to-back transactions leave SS_n high for at least 1 clk.
- SCLK never toggles while SS_n=1.

Test Plan:
- Reset mid-transaction:
  - Stimulus: wrt with cmd=0x8F00, assert rst_n=0 at cycle 200, then release.
  - Required: SS_n=1, SCLK=1, done=0, rd_data=0 immediately. No SCLK edges occur after the reset.
- WHO_AM_I read against the sensor model:
  - Stimulus: wait out the model's power-on delay, then wrt with cmd=0x8F00.
  - Required: done at +520 cycles, rd_data[7:0]=0x6A, exactly 16 SCLK rising edges while SS_n=0.
- Register writes:
  - Stimulus: write cmd=0x0D02, then cmd=0x1160.
  - Required: each returns rd_data[7:0]=0xA5. Once both writes complete, the model's INT pin begins pulsing.
- YAW read:
  - Stimulus: drive the model's YAW input to 0x1234, read 0xA600, then 0xA700.
  - Required: rd_data[7:0]=0x34 then 0x12. INT clears after the 0xA6 read.
- Timing check:
  - Required: MOSI changes only within 1 clk after an SCLK fall; MISO is sampled on SCLK rise; MOSI order is 1,0,0,0,1,1,1,1,0... for 0x8F00.
  - Required: SCLK period is 32 clk, 16 high and 16 low.
- Handshake corner cases:
  - Stimulus: wrt pulses at cycles 100 and 300 during a transaction.
  - Required: both ignored; rd_data reflects only the first cmd.
  - Stimulus: wrt the cycle after done rises.
  - Required: done drops the next cycle and SS_n falls again.
